mode_ctrl: RTL and testbench

- Navigation FSM that produces the 5-bit mode code consumed by the motor driver (the producer end of the mode/lastMode interface).
- Reads debounced line sensors and a route-plan turn direction; emits mode, lastMode and a route-advance pulse.
- Sits between the sensor/route blocks and the motor driver in the car top level.

---
 rtl/carmode_pkg.sv | 54 +++++
 rtl/sensor_debounce.sv | 37 +++
 rtl/mode_ctrl.sv | 127 ++++++++++++
 tb/tb_mode_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/carmode_pkg.sv
// Mode codes and route-plan encodings shared by mode_ctrl and the motor driver.
package carmode_pkg;

  localparam logic [4:0] MODE_IDLE         = 5'd0;
  localparam logic [4:0] MODE_START        = 5'd1;
  localparam logic [4:0] MODE_COUNT        = 5'd2;
  localparam logic [4:0] MODE_STRAIGHT     = 5'd3;
  localparam logic [4:0] MODE_CHOOSE       = 5'd4;
  localparam logic [4:0] MODE_LEFT         = 5'd5;
  localparam logic [4:0] MODE_RIGHT        = 5'd6;
  localparam logic [4:0] MODE_BACK         = 5'd7;
  localparam logic [4:0] MODE_LITTLE_LEFT  = 5'd8;
  localparam logic [4:0] MODE_LITTLE_RIGHT = 5'd9;
  localparam logic [4:0] MODE_STEP1        = 5'd10;
  localparam logic [4:0] MODE_STEP2        = 5'd11;
  localparam logic [4:0] MODE_STEP3        = 5'd12;
  localparam logic [4:0] MODE_FINISH       = 5'd29;
  localparam logic [4:0] MODE_STOP         = 5'd30;
  localparam logic [4:0] MODE_ERROR        = 5'd31;

  localparam logic [1:0] TURN_STRAIGHT = 2'b00;
  localparam logic [1:0] TURN_LEFT     = 2'b01;
  localparam logic [1:0] TURN_RIGHT    = 2'b10;
  localparam logic [1:0] TURN_FINISH   = 2'b11;

  typedef enum logic [4:0] {
    M_IDLE         = MODE_IDLE,
    M_START        = MODE_START,
    M_COUNT        = MODE_COUNT,
    M_STRAIGHT     = MODE_STRAIGHT,
    M_CHOOSE       = MODE_CHOOSE,
    M_LEFT         = MODE_LEFT,
    M_RIGHT        = MODE_RIGHT,
    M_BACK         = MODE_BACK,
    M_LITTLE_LEFT  = MODE_LITTLE_LEFT,
    M_LITTLE_RIGHT = MODE_LITTLE_RIGHT,
    M_STEP1        = MODE_STEP1,
    M_STEP2        = MODE_STEP2,
    M_STEP3        = MODE_STEP3,
    M_FINISH       = MODE_FINISH,
    M_STOP         = MODE_STOP,
    M_ERROR        = MODE_ERROR
  } mode_e;

  function automatic logic is_follow(mode_e m);
    return (m == M_STRAIGHT) || (m == M_LITTLE_LEFT) || (m == M_LITTLE_RIGHT);
  endfunction

  // Modes in which the car is moving and an obstacle may interrupt it.
  function automatic logic is_motion(mode_e m);
    return (m >= M_STRAIGHT) && (m <= M_STEP3);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Line-sensor debouncer: a pattern is passed on once it has been sampled
// unchanged DEB_CYC+1 times in a row.
module sensor_debounce #(
  parameter int unsigned DEB_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw_i,
  output logic [2:0] deb_o
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic [2:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    deb_q;

  // cnt_q saturates at CNT_LAST; while it sits there the candidate is live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= 3'b000;
      cnt_q  <= '0;
      deb_q  <= 3'b000;
    end else if (raw_i != cand_q) begin
      cand_q <= raw_i;
      cnt_q  <= '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_q  <= cand_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/mode_ctrl.sv
// Navigation FSM producing the motor-driver mode code from debounced line
// sensors and the route plan. Define MODE_CTRL_SONIC_STOP_EN for obstacle pause.
module mode_ctrl
  import carmode_pkg::*;
#(
  parameter int unsigned DEB_CYC      = 100_000,
  parameter int unsigned START_CYC    = 300_000_000,
  parameter int unsigned CHOOSE_CYC   = 20_000_000,
  parameter int unsigned STEP_CYC     = 30_000_000,
  parameter int unsigned MIN_TURN_CYC = 30_000_000,
  parameter int unsigned TURN_TO_CYC  = 200_000_000,
  parameter int unsigned LOST_CYC     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] sensor,
  input  logic [1:0] turn_dir,
  input  logic       sonic_stop,
  output logic [4:0] mode,
  output logic [4:0] lastMode,
  output logic       route_adv
);

  localparam logic [31:0] START_LAST  = 32'(START_CYC - 1);
  localparam logic [31:0] CHOOSE_LAST = 32'(CHOOSE_CYC - 1);
  localparam logic [31:0] STEP_LAST   = 32'(STEP_CYC - 1);
  localparam logic [31:0] TURN_MIN    = 32'(MIN_TURN_CYC);
  localparam logic [31:0] TURN_LAST   = 32'(TURN_TO_CYC - 1);
  localparam logic [31:0] LOST_LAST   = 32'(LOST_CYC - 1);

  mode_e       mode_q, mode_d, last_q;
  logic [31:0] timer_q, lost_q, lost_d;
  logic        adv_q, adv_d;
  logic [2:0]  s;

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .raw_i (sensor),
    .deb_o (s)
  );

`ifndef MODE_CTRL_SONIC_STOP_EN
  logic unused_sonic;
  assign unused_sonic = sonic_stop;
`endif

  always_comb begin
    mode_d = mode_q;
    adv_d  = 1'b0;
    case (mode_q)
      M_IDLE:  if (start) mode_d = M_START;
      M_START: mode_d = M_COUNT;
      M_COUNT: if (timer_q == START_LAST) mode_d = M_STRAIGHT;
      M_STRAIGHT, M_LITTLE_LEFT, M_LITTLE_RIGHT: begin
        case (s)
          3'b010:         mode_d = M_STRAIGHT;
          3'b100, 3'b110: mode_d = M_LITTLE_LEFT;
          3'b001, 3'b011: mode_d = M_LITTLE_RIGHT;
          3'b111:         mode_d = M_CHOOSE;
          3'b101:         mode_d = M_ERROR;
          default:        if (lost_q == LOST_LAST) mode_d = M_STEP1;
        endcase
      end
      M_CHOOSE: begin
        if (timer_q == CHOOSE_LAST) begin
          adv_d = 1'b1;
          case (turn_dir)
            TURN_STRAIGHT: mode_d = M_STRAIGHT;
            TURN_LEFT:     mode_d = M_LEFT;
            TURN_RIGHT:    mode_d = M_RIGHT;
            default:       mode_d = M_FINISH;
          endcase
        end
      end
      M_LEFT, M_RIGHT, M_BACK: begin
        // A valid exit wins over a timeout landing on the same cycle.
        if (timer_q >= TURN_MIN && s == 3'b010) mode_d = M_STRAIGHT;
        else if (timer_q == TURN_LAST)          mode_d = M_ERROR;
      end
      M_STEP1: if (timer_q == STEP_LAST) mode_d = M_STEP2;
      M_STEP2: if (timer_q == STEP_LAST) mode_d = M_STEP3;
      M_STEP3: if (timer_q == STEP_LAST) mode_d = M_BACK;
`ifdef MODE_CTRL_SONIC_STOP_EN
      M_STOP:  if (!sonic_stop) mode_d = last_q;
`endif
      default: ;
    endcase
`ifdef MODE_CTRL_SONIC_STOP_EN
    // Obstacle overrides everything, including consuming the route entry.
    if (sonic_stop && is_motion(mode_q)) begin
      mode_d = M_STOP;
      adv_d  = 1'b0;
    end
`endif
  end

  // Length of the current all-white run while line following.
  assign lost_d = (is_follow(mode_q) && s == 3'b000 && mode_d == mode_q)
                  ? lost_q + 32'd1 : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= M_IDLE;
      last_q  <= M_IDLE;
      timer_q <= '0;
      lost_q  <= '0;
      adv_q   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      adv_q  <= adv_d;
      lost_q <= lost_d;
      if (mode_d != mode_q) begin
        last_q  <= mode_q;
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 32'd1;
      end
    end
  end

  assign mode      = mode_q;
  assign lastMode  = last_q;
  assign route_adv = adv_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed/random bench for mode_ctrl against a behavioural navigation model.
module tb_mode_ctrl;

  localparam int DEB = 2, STARTC = 10, CHOOSE = 4, STEP = 3;
  localparam int MINT = 3, TTO = 20, LOST = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sonic = 1'b0;
  logic [2:0] sensor = 3'b000;
  logic [1:0] turn = 2'b00;
  logic [4:0] mode, lastm;
  logic       adv;

  always #5 clk = ~clk;

  mode_ctrl #(
    .DEB_CYC(DEB), .START_CYC(STARTC), .CHOOSE_CYC(CHOOSE), .STEP_CYC(STEP),
    .MIN_TURN_CYC(MINT), .TURN_TO_CYC(TTO), .LOST_CYC(LOST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sensor(sensor), .turn_dir(turn),
    .sonic_stop(sonic), .mode(mode), .lastMode(lastm), .route_adv(adv)
  );

  int errs = 0, checks = 0;
  // Model: mode numbers, time of entry into current mode, white-run length.
  int m_mode, m_last, m_adv, m_enter, m_white, m_s, cyc = 0;
  int hist[$];
  int pool[6] = '{2, 4, 6, 1, 3, 0};

  function automatic bit follow(int md);
    return md == 3 || md == 8 || md == 9;
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input int exp);
    checks++;
    assert (obs === exp[4:0]) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_adv = 0; m_enter = cyc; m_white = 0; m_s = 0;
    hist = {};
    repeat (DEB + 1) hist.push_back(0);
  endtask

  task automatic model_edge();
    int t, nm, a, run;
    bit same;
    t = cyc - m_enter; nm = m_mode; a = 0;
    run = (follow(m_mode) && m_s == 0) ? m_white + 1 : 0;
    case (m_mode)
      0: if (start) nm = 1;
      1: nm = 2;
      2: if (t == STARTC - 1) nm = 3;
      3, 8, 9:
        case (m_s)
          2:       nm = 3;
          4, 6:    nm = 8;
          1, 3:    nm = 9;
          7:       nm = 4;
          5:       nm = 31;
          default: if (run >= LOST) nm = 10;
        endcase
      4: if (t == CHOOSE - 1) begin
           a = 1;
           nm = (turn == 0) ? 3 : (turn == 1) ? 5 : (turn == 2) ? 6 : 29;
         end
      5, 6, 7: if (t >= MINT && m_s == 2) nm = 3; else if (t >= TTO - 1) nm = 31;
      10: if (t == STEP - 1) nm = 11;
      11: if (t == STEP - 1) nm = 12;
      12: if (t == STEP - 1) nm = 7;
      30: if (!sonic) nm = m_last;
      default: ;
    endcase
`ifdef MODE_CTRL_SONIC_STOP_EN
    if (sonic && m_mode >= 3 && m_mode <= 12) begin nm = 30; a = 0; end
`endif
    m_white = (nm == m_mode) ? run : 0;
    if (nm != m_mode) begin m_last = m_mode; m_mode = nm; m_enter = cyc + 1; end
    m_adv = a;
    hist.push_back(int'(sensor));
    if (hist.size() > DEB + 1) void'(hist.pop_front());
    same = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
    if (same) m_s = hist[0];
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    chk("mode", mode, m_mode);
    chk("lastMode", lastm, m_last);
    chk("route_adv", {4'b0, adv}, m_adv);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Asserted mid-cycle so the async clear is observed without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    start = 1'b0; sonic = 1'b0;
    #1;
    model_reset();
    chk("rst_mode", mode, 0);
    chk("rst_last", lastm, 0);
    chk("rst_adv", {4'b0, adv}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic go();
    sensor = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    run(STARTC + 1);
    chk("go_mode", mode, 3);
    chk("go_last", lastm, 2);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Episode A: follow, intersections, dead-end recovery, then 101.
    go();
    sensor = 3'b110; run(5);
    sensor = 3'b011; run(5);
    sensor = 3'b010; run(4);
    repeat (15) begin
      sensor = 3'(pool[$urandom_range(0, 5)]);
      run($urandom_range(1, 5));
    end
    sensor = 3'b010; run(25);
    repeat (3) begin
      sensor = 3'b010; run(4);
      sensor = 3'b111; turn = 2'($urandom_range(0, 2)); run(3);
      sensor = 3'b000; run($urandom_range(4, 6));
      sensor = 3'b010; run(8);
    end
    sensor = 3'b010; run(25);
    sensor = 3'b000; run(20);
    sensor = 3'b010; run(8);
    sensor = 3'b101; run(6);
    chk("err_101", mode, 31);
    start = 1'b1; tick(); start = 1'b0; run(3);
    chk("err_start", mode, 31);

    // Episode B: lost, BACK never finds the line -> timeout.
    do_reset();
    go();
    sensor = 3'b000; run(45);
    chk("back_to_mode", mode, 31);
    chk("back_to_last", lastm, 7);

    // Episode C: finish entry.
    do_reset();
    go();
    sensor = 3'b111; turn = 2'b11; run(3);
    sensor = 3'b000; run(8);
    chk("fin_mode", mode, 29);
    chk("fin_last", lastm, 4);
    start = 1'b1; tick(); start = 1'b0; run(2);
    chk("fin_start", mode, 29);

    // Episode D: reset in the middle of CHOOSE.
    do_reset();
    go();
    sensor = 3'b111; turn = 2'($urandom_range(0, 3)); run(3);
    for (int k = 0; k < 10 && mode !== 5'd4; k++) tick();
    chk("wait_choose", mode, 4);
    tick();
    do_reset();

    // Episode E: obstacle during a right turn and during following.
    go();
    sensor = 3'b111; turn = 2'b10; run(3);
    sensor = 3'b000; run(6);
    chk("in_right", mode, 6);
    sonic = 1'b1; run(3);
`ifdef MODE_CTRL_SONIC_STOP_EN
    chk("stop_mode", mode, 30);
    chk("stop_last", lastm, 6);
`else
    chk("nostop_mode", mode, 6);
`endif
    sonic = 1'b0; run(2);
    chk("resume_mode", mode, 6);
    sensor = 3'b010; run(25);
    repeat (12) begin
      sonic = 1'($urandom_range(0, 1));
      sensor = 3'(pool[$urandom_range(0, 4)]);
      run($urandom_range(1, 4));
    end
    sonic = 1'b0; run(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
